uart_rx_loader: RTL and testbench

UART_RX_LOADER -- requirements
Module: uart_rx_loader

---
 rtl/uart_rx_loader.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_loader.sv
// UART receiver that packs four received bytes (little-endian) into a 32-bit RAM write.
// Optional even parity (8E1) when UART_RX_PARITY_EN is defined; default build is 8N1.
module uart_rx_loader #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              Rx_Serial,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              frame_err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state, state_next;
  logic        rx_meta, rx_sync;
  logic [1:0]  sync_fill;
  logic        armed;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic        cnt_clr, data_tick, byte_ok, byte_bad, parity_ok;

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  logic parity_tick;
  assign parity_ok = ~^{shift_reg, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  assign busy = (state != IDLE);

  // A start is only recognised once the synchronized line has really been seen high,
  // so a line held low across reset release (or after a broken stop bit) cannot open a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= Rx_Serial;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      if (byte_bad && !rx_sync)
        armed <= 1'b0;
      else if (sync_fill[1] && rx_sync)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    data_tick  = 1'b0;
    byte_ok    = 1'b0;
    byte_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_tick = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (armed && !rx_sync) state_next = START;
      end
      START: begin
        if (clk_cnt == HALF_M1) begin
          cnt_clr    = 1'b1;
          state_next = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == FULL_M1) begin
          cnt_clr   = 1'b1;
          data_tick = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_next = PARITY;
`else
          if (bit_cnt == 3'd7) state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == FULL_M1) begin
          cnt_clr     = 1'b1;
          parity_tick = 1'b1;
          state_next  = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == FULL_M1) begin
          cnt_clr    = 1'b1;
          state_next = IDLE;
          if (rx_sync && parity_ok) byte_ok  = 1'b1;
          else                      byte_bad = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Dropping enable aborts silently: no write, no error.
    if (!enable) begin
      state_next = IDLE;
      cnt_clr    = 1'b1;
      data_tick  = 1'b0;
      byte_ok    = 1'b0;
      byte_bad   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      clk_cnt <= cnt_clr ? 16'd0 : clk_cnt + 16'd1;
      if (state == IDLE)  bit_cnt <= 3'd0;
      else if (data_tick) bit_cnt <= bit_cnt + 3'd1;
      if (data_tick) shift_reg <= {rx_sync, shift_reg[7:1]};
`ifdef UART_RX_PARITY_EN
      if (parity_tick) parity_bit <= rx_sync;
`endif
    end
  end

  // Bytes collect in word_buf; the fourth completes the word and fires the write strobe,
  // and the address advances in the cycle after the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_err  <= 1'b0;
      word_count <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
    end else if (!enable) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_err  <= 1'b0;
      word_count <= '0;
      byte_idx   <= '0;
    end else begin
      wr_en     <= 1'b0;
      wr_data   <= '0;
      frame_err <= byte_bad;
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      if (byte_ok) begin
        if (byte_idx == 2'd3) begin
          wr_en    <= 1'b1;
          wr_data  <= {shift_reg, word_buf};
          byte_idx <= 2'd0;
          if (word_count != '1) word_count <= word_count + 1'b1;
        end else begin
          case (byte_idx)
            2'd0:    word_buf[7:0]   <= shift_reg;
            2'd1:    word_buf[15:8]  <= shift_reg;
            default: word_buf[23:16] <= shift_reg;
          endcase
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Scoreboard bench for uart_rx_loader at CLKS_PER_BIT=16, ADDR_W=4.
// Define UART_RX_PARITY_EN for both files to exercise the 8E1 build.
module tb_uart_rx_loader;

  localparam int CPB    = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              Rx_Serial;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              frame_err;
  logic [ADDR_W:0]   word_count;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_count = 0;
  int wr_count = 0;
  logic prev_wr_en = 1'b0;

  logic [ADDR_W+31:0] sb_q[$];
  logic [ADDR_W-1:0]  exp_addr  = '0;
  int                 exp_count = 0;

  uart_rx_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .Rx_Serial(Rx_Serial),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_err(frame_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One serial frame, driven on falling edges; line left idle high afterwards.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    Rx_Serial = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      Rx_Serial = b[i];
      idle(CPB);
    end
`ifdef UART_RX_PARITY_EN
    Rx_Serial = (^b) ^ par_flip;
    idle(CPB);
`else
    if (par_flip) $display("[TB] note: parity flip ignored in 8N1 build");
`endif
    Rx_Serial = stop_bit;
    idle(CPB);
    Rx_Serial = 1'b1;
  endtask

  task automatic push_expected(input logic [31:0] w);
    sb_q.push_back({exp_addr, w});
    exp_addr  = exp_addr + 1'b1;
    exp_count = (exp_count < 31) ? exp_count + 1 : 31;
  endtask

  task automatic send_word(input logic [31:0] w);
    push_expected(w);
    for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], 1'b1, 1'b0);
  endtask

  task automatic restart_enable();
    enable = 1'b0;
    idle(2);
    exp_addr  = '0;
    exp_count = 0;
    enable = 1'b1;
    idle(4);
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) fe_count++;
      if (wr_en) begin
        wr_count++;
        checkOutput("wr_en_width", prev_wr_en, 1'b0);
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_wr_en", wr_en, 1'b0);
        end else begin
          logic [ADDR_W+31:0] e;
          e = sb_q.pop_front();
          checkOutput("wr_addr", wr_addr, e[ADDR_W+31:32]);
          checkOutput("wr_data", wr_data, e[31:0]);
        end
      end
      prev_wr_en = wr_en;
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fe0, wc0, hits, got;
    logic [7:0] b2;

    reset = 1'b0; enable = 1'b1; Rx_Serial = 1'b0;
    idle(3);
    checkOutput("rst_wr_en",      wr_en,      0);
    checkOutput("rst_wr_addr",    wr_addr,    0);
    checkOutput("rst_wr_data",    wr_data,    0);
    checkOutput("rst_busy",       busy,       0);
    checkOutput("rst_frame_err",  frame_err,  0);
    checkOutput("rst_word_count", word_count, 0);

    // Reset released while the line is low: nothing may start.
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) hits++;
    end
    checkOutput("no_frame_low_line", hits, 0);
    Rx_Serial = 1'b1;
    idle(20);

    // Basic word
    send_word(32'h12345678);
    idle(4);
    checkOutput("word_count_1", word_count, 1);
    checkOutput("wr_data_idle", wr_data, 0);
    checkOutput("drain_1", sb_q.size(), 0);

    // Bad stop bit, then a good word
    fe0 = fe_count; wc0 = wr_count;
    applyStimulus(8'hAA, 1'b0, 1'b0);
    idle(32);
    checkOutput("stop_err_pulse", fe_count - fe0, 1);
    checkOutput("stop_err_no_wr", wr_count - wc0, 0);
    send_word(32'h04030201);
    idle(4);
    checkOutput("drain_2", sb_q.size(), 0);

    // Short glitch on the idle line
    fe0 = fe_count; wc0 = wr_count;
    Rx_Serial = 1'b0;
    idle(4);
    Rx_Serial = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) got = 1;
    end
    checkOutput("glitch_busy_rise", got, 1);
    idle(30);
    checkOutput("glitch_idle", busy, 0);
    checkOutput("glitch_no_err", fe_count - fe0, 0);
    checkOutput("glitch_no_wr", wr_count - wc0, 0);
    checkOutput("glitch_count", word_count, exp_count);

    // Abort via enable in the middle of the third byte
    fe0 = fe_count; wc0 = wr_count;
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    b2 = 8'h5C;
    Rx_Serial = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      Rx_Serial = b2[i];
      idle(CPB);
    end
    checkOutput("abort_busy_before", busy, 1);
    enable = 1'b0;
    Rx_Serial = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy_after", busy, 0);
    checkOutput("abort_wr_addr", wr_addr, 0);
    checkOutput("abort_word_count", word_count, 0);
    exp_addr = '0; exp_count = 0;
    idle(5);
    checkOutput("abort_no_err", fe_count - fe0, 0);
    checkOutput("abort_no_wr", wr_count - wc0, 0);
    enable = 1'b1;
    idle(20);
    send_word(32'hCAFE0042);
    idle(4);
    checkOutput("reenable_count", word_count, exp_count);

    // Address wrap and count saturation
    restart_enable();
    for (int n = 0; n < 17; n++) send_word($urandom);
    idle(4);
    checkOutput("count_17", word_count, 17);
    checkOutput("addr_after_17", wr_addr, 1);
    for (int n = 0; n < 15; n++) send_word($urandom);
    idle(4);
    checkOutput("count_saturated", word_count, 31);
    send_word($urandom);
    idle(4);
    checkOutput("count_held", word_count, 31);

`ifdef UART_RX_PARITY_EN
    fe0 = fe_count; wc0 = wr_count;
    applyStimulus(8'h03, 1'b1, 1'b1);
    idle(8);
    checkOutput("parity_err_pulse", fe_count - fe0, 1);
    checkOutput("parity_err_no_wr", wr_count - wc0, 0);
    send_word(32'h00000003);
    idle(4);
    checkOutput("parity_good_wr", wr_count - wc0, 1);
`endif

    idle(10);
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
